// File: rtl/shift_pkg.sv
// Shared types and sizes for the pipelined shift unit.
// Op 2'b11 is ROR only when SHIFT_ROTATE_EN is defined, otherwise it is reported as illegal.
package shift_pkg;
  localparam int SHIFT_N   = 32;
  localparam int SHIFT_SHW = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_t;
endpackage

// File: rtl/barrel_shift_right.sv
// Combinational logarithmic right shifter: one 2:1 mux rank per shift-amount bit.
// Vacated MSBs take fill_bit_i, so the same core serves SRL, SRA and reversed SLL.
module barrel_shift_right
  import shift_pkg::*;
#(
  parameter int N   = SHIFT_N,
  parameter int SHW = SHIFT_SHW
) (
  input  logic [N-1:0]   data_i,
  input  logic [SHW-1:0] shamt_i,
  input  logic           fill_bit_i,
  output logic [N-1:0]   data_o
);

  logic [N-1:0] stage [SHW+1];

  assign stage[0] = data_i;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    assign stage[s+1] = shamt_i[s] ? {{(2**s){fill_bit_i}}, stage[s][N-1:2**s]} : stage[s];
  end

  assign data_o = stage[SHW];

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage SLL/SRL/SRA shift unit with valid/ready on both sides; S1 holds operands, S2 the result.
// Build option SHIFT_ROTATE_EN turns op 2'b11 into ROR; without it that op yields data 0 and err 1.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int N   = SHIFT_N,
  parameter int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [SHW-1:0] in_shamt,
  input  logic [1:0]     in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_err
);

  logic           s1_valid_q;
  logic [N-1:0]   s1_data_q;
  logic [SHW-1:0] s1_shamt_q;
  logic [1:0]     s1_op_q;
  logic           out_valid_q;
  logic [N-1:0]   out_data_q;
  logic           out_err_q;

  logic           s1_adv, s2_adv, in_fire;
  logic [N-1:0]   core_in, core_out, rev_data, rev_core;
  logic           core_fill;
  logic [N-1:0]   out_data_d;
  logic           out_err_d;
  shift_op_t      op_e;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // SLL reuses the right shifter by mirroring the operand and the result.
  for (genvar i = 0; i < N; i++) begin : g_rev
    assign rev_data[i] = s1_data_q[N-1-i];
    assign rev_core[i] = core_out[N-1-i];
  end

  assign op_e      = shift_op_t'(s1_op_q);
  assign core_in   = (op_e == SH_SLL) ? rev_data : s1_data_q;
  assign core_fill = (op_e == SH_SRA) && s1_data_q[N-1];

  barrel_shift_right #(.N(N), .SHW(SHW)) u_core (
    .data_i     (core_in),
    .shamt_i    (s1_shamt_q),
    .fill_bit_i (core_fill),
    .data_o     (core_out)
  );

`ifdef SHIFT_ROTATE_EN
  localparam logic [SHW:0] N_W = (SHW+1)'(N);
  logic [SHW:0] rot_amt;
  logic [N-1:0] rot_hi;

  // Bits wrapped around into the top; empty for a zero rotate.
  assign rot_amt = N_W - {1'b0, s1_shamt_q};
  assign rot_hi  = (s1_shamt_q == '0) ? '0 : (s1_data_q << rot_amt);
`endif

  always_comb begin
    out_data_d = '0;
    out_err_d  = 1'b0;
    unique case (op_e)
      SH_SLL:         out_data_d = rev_core;
      SH_SRL, SH_SRA: out_data_d = core_out;
      default: begin
`ifdef SHIFT_ROTATE_EN
        out_data_d = core_out | rot_hi;
`else
        out_err_d  = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_shamt_q  <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= in_data;
        s1_shamt_q <= in_shamt;
        s1_op_q    <= in_op;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= out_data_d;
          out_err_q  <= out_err_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed and random checks of shift_unit_pipe against an arithmetic reference model and an in-order scoreboard.
module tb_shift_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q [$];
  int          occ = 0;
  logic        last_in_fire;
  int          out_count = 0;

  always #5 clk = ~clk;

  shift_unit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  // Returns {err, data}.
  function automatic logic [32:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int sh);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = $signed(d) >>> sh;
      default: begin
`ifdef SHIFT_ROTATE_EN
        r = (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
`else
        r = 32'h0;
        e = 1'b1;
`endif
      end
    endcase
    return {e, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven; check at negedge, then advance past the posedge.
  task automatic cycle();
    logic       out_fire;
    logic [32:0] e;
    @(negedge clk);
    last_in_fire = in_valid && in_ready;
    out_fire     = out_valid && out_ready;
    if (rst) begin
      exp_q.delete();
      occ = 0;
      last_in_fire = 1'b0;
    end else begin
      chk("in_ready_model", {31'h0, in_ready}, {31'h0, (occ < 2) || out_ready});
      if (out_valid) chk("valid_with_pending", {31'h0, exp_q.size() != 0}, 32'h1);
      if (out_fire && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e[31:0]);
        chk("sb_err", {31'h0, out_err}, {31'h0, e[32]});
        out_count++;
      end
      if (last_in_fire) exp_q.push_back(ref_shift(in_op, in_data, int'(in_shamt)));
      occ = occ + int'(last_in_fire) - int'(out_fire);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
  endtask

  initial begin
    logic [1:0]  t4_op [4];
    logic [31:0] t4_d  [4];
    logic [4:0]  t4_sh [4];
    int idx;
    int budget;

    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    @(posedge clk);
    #1;

    // 1: reset held two cycles
    cycle();
    cycle();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;

    // 2: SRL latency
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h8000_0000, 5'd4);
    cycle();
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    chk("srl_not_early", {31'h0, out_valid}, 32'h0);
    cycle();
    chk("srl_valid", {31'h0, out_valid}, 32'h1);
    chk("srl_data", out_data, 32'h0800_0000);
    cycle();

    // 3: SRA and SLL at maximum shift
    drive(1'b1, 2'b10, 32'hF000_000F, 5'd8);
    cycle();
    drive(1'b1, 2'b00, 32'h0000_0001, 5'd31);
    cycle();
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    chk("sra_data", out_data, 32'hFFF0_0000);
    cycle();
    chk("sll31_data", out_data, 32'h8000_0000);
    cycle();

    // 5: op 2'b11
    drive(1'b1, 2'b11, 32'h0000_00F1, 5'd4);
    cycle();
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    cycle();
`ifdef SHIFT_ROTATE_EN
    chk("op3_data", out_data, 32'h1000_000F);
    chk("op3_err", {31'h0, out_err}, 32'h0);
`else
    chk("op3_data", out_data, 32'h0);
    chk("op3_err", {31'h0, out_err}, 32'h1);
`endif
    cycle();

    // 4: back-to-back with a three-cycle output stall
    t4_op = '{2'b00, 2'b01, 2'b10, 2'b00};
    t4_d  = '{32'h1234_5678, 32'h8765_4321, 32'h8000_0001, 32'hDEAD_BEEF};
    t4_sh = '{5'd3, 5'd7, 5'd0, 5'd16};
    out_count = 0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c >= 3);
      if (idx < 4) drive(1'b1, t4_op[idx], t4_d[idx], t4_sh[idx]);
      else         drive(1'b0, 2'b00, 32'h0, 5'd0);
      if (c == 2) chk("b2b_in_ready_low", {31'h0, in_ready}, 32'h0);
      cycle();
      if (last_in_fire) idx++;
      if (idx == 4 && exp_q.size() == 0) break;
    end
    chk("b2b_out_count", out_count, 32'd4);
    chk("b2b_pending", exp_q.size(), 32'd0);

    // 6: reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd1);
    cycle();
    drive(1'b1, 2'b00, 32'h0000_FFFF, 5'd2);
    cycle();
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    chk("full_valid", {31'h0, out_valid}, 32'h1);
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    cycle();
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_out_data", out_data, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("no_stale", {31'h0, out_valid}, 32'h0);
    end

    // Random traffic with random stalls
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_in_fire) begin
        drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom(),
              ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0)
                                          : 5'($urandom_range(0, 31)));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    drive(1'b0, 2'b00, 32'h0, 5'd0);
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      cycle();
      budget++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
